// File: rtl/lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl
// Sequencer for a runtime-configurable Fibonacci LFSR. Holds the seed and tap
// registers, steps the LFSR once per cycle while shifting, packs the output
// bits MSB-first into words and hands each word downstream over valid/ready.
// A run produces a programmed number of words, or runs continuously
// (i_num_words == 0) until i_stop.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_cfg_we       config write (IDLE only): i_cfg_seed -> seed and state,
//                  i_cfg_taps -> taps, clears o_lockup
//   i_start        start a run (IDLE only), samples i_num_words
//   i_num_words    words per run, 0 = continuous
//   i_stop         abort the current run (SHIFT/PRESENT)
//   i_ready        downstream accepts o_word
//   o_word/o_valid packed random word and its valid flag
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse at the end of a run
//   o_lockup       sticky flag: an all-zero state was found and reloaded
//   o_state        current LFSR state
// -----------------------------------------------------------------------------
module lfsr_seq_ctrl #(
   parameter int                 NUM_BITS  = 5,
   parameter int                 WORD_BITS = 8,
   parameter logic [NUM_BITS-1:0] SEED     = 5'd1,
   parameter logic [NUM_BITS-1:0] TAPS     = 5'h14
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cfg_we,
   input  logic [NUM_BITS-1:0]  i_cfg_seed,
   input  logic [NUM_BITS-1:0]  i_cfg_taps,
   input  logic                 i_start,
   input  logic [7:0]           i_num_words,
   input  logic                 i_stop,
   input  logic                 i_ready,
   output logic [WORD_BITS-1:0] o_word,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_lockup,
   output logic [NUM_BITS-1:0]  o_state
);

   localparam int CNT_W = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } fsm_t;

   fsm_t                 fsm;
   logic [NUM_BITS-1:0]  state;
   logic [NUM_BITS-1:0]  seed_reg;
   logic [NUM_BITS-1:0]  taps_reg;
   logic [CNT_W-1:0]     bit_cnt;
   logic [7:0]           word_cnt;
   logic [7:0]           num_words;
   logic [WORD_BITS-1:0] word_sh;

   logic [NUM_BITS-1:0]  state_next;
   logic [WORD_BITS-1:0] word_next;
   logic                 last_word;

   // Fibonacci feedback: parity of the tapped state bits.
   function automatic logic lfsr_fb(input logic [NUM_BITS-1:0] s,
                                    input logic [NUM_BITS-1:0] t);
      return ^(s & t);
   endfunction

   // Next LFSR state and packed word for one step; the MSB shifts out.
   assign state_next = {state[NUM_BITS-2:0], lfsr_fb(state, taps_reg)};
   assign word_next  = {word_sh[WORD_BITS-2:0], state[NUM_BITS-1]};
   // word_cnt+1 is evaluated at 8 bits so it wraps like the counter itself.
   assign last_word  = (num_words != 8'd0) && ((word_cnt + 8'd1) == num_words);

   assign o_state = state;

   // Sequencer FSM, LFSR datapath and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fsm       <= IDLE;
         state     <= SEED;
         seed_reg  <= SEED;
         taps_reg  <= TAPS;
         bit_cnt   <= '0;
         word_cnt  <= 8'd0;
         num_words <= 8'd0;
         word_sh   <= '0;
         o_word    <= '0;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_lockup  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (fsm)
            IDLE: begin
               // Config write has priority; a simultaneous start is dropped.
               if (i_cfg_we) begin
                  seed_reg <= i_cfg_seed;
                  state    <= i_cfg_seed;
                  taps_reg <= i_cfg_taps;
                  o_lockup <= 1'b0;
               end else if (i_start) begin
                  num_words <= i_num_words;
                  word_cnt  <= 8'd0;
                  bit_cnt   <= '0;
                  fsm       <= SHIFT;
                  o_busy    <= 1'b1;
               end
            end

            SHIFT: begin
               if (i_stop) begin
                  // Partial word is discarded; steps already taken are kept.
                  bit_cnt <= '0;
                  fsm     <= DONE;
                  o_done  <= 1'b1;
               end else if ((bit_cnt == '0) && (state == '0)) begin
                  // All-zero lockup: reload instead of stepping; the word
                  // starts on the next cycle with bit_cnt still at zero.
                  state    <= (seed_reg == '0) ? SEED : seed_reg;
                  o_lockup <= 1'b1;
               end else begin
                  state   <= state_next;
                  word_sh <= word_next;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     o_word  <= word_next;
                     o_valid <= 1'b1;
                     fsm     <= PRESENT;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            PRESENT: begin
               // LFSR is frozen here so backpressure never loses bits.
               if (i_ready) begin
                  o_valid  <= 1'b0;
                  word_cnt <= word_cnt + 8'd1;
                  if (i_stop || last_word) begin
                     fsm    <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     fsm <= SHIFT;
                  end
               end else if (i_stop) begin
                  o_valid <= 1'b0;
                  fsm     <= DONE;
                  o_done  <= 1'b1;
               end
            end

            DONE: begin
               fsm    <= IDLE;
               o_busy <= 1'b0;
            end

            default: begin
               fsm     <= IDLE;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lfsr_seq_ctrl
// Directed self-checking bench for lfsr_seq_ctrl with default parameters
// (5-bit LFSR, taps 5'h14, 8-bit words). Expected words and states are
// hand-derived from the sequence 01,02,04,09,12,05,0B,16,0C,19,13,07,0F,...
// whose first words are 8'h09, 8'h67, 8'hC6.
// -----------------------------------------------------------------------------
module tb_lfsr_seq_ctrl;

   logic       clk;
   logic       i_rst;
   logic       i_cfg_we;
   logic [4:0] i_cfg_seed;
   logic [4:0] i_cfg_taps;
   logic       i_start;
   logic [7:0] i_num_words;
   logic       i_stop;
   logic       i_ready;
   logic [7:0] o_word;
   logic       o_valid;
   logic       o_busy;
   logic       o_done;
   logic       o_lockup;
   logic [4:0] o_state;

   int errors = 0;
   int checks = 0;

   lfsr_seq_ctrl dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_cfg_we    (i_cfg_we),
      .i_cfg_seed  (i_cfg_seed),
      .i_cfg_taps  (i_cfg_taps),
      .i_start     (i_start),
      .i_num_words (i_num_words),
      .i_stop      (i_stop),
      .i_ready     (i_ready),
      .o_word      (o_word),
      .o_valid     (o_valid),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_lockup    (o_lockup),
      .o_state     (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   task automatic cfg(input logic [4:0] seed, input logic [4:0] taps);
      i_cfg_we = 1'b1; i_cfg_seed = seed; i_cfg_taps = taps;
      tick();
      i_cfg_we = 1'b0;
   endtask

   task automatic start(input logic [7:0] nw);
      i_start = 1'b1; i_num_words = nw;
      tick();
      i_start = 1'b0;
   endtask

   // Cycles until o_valid is seen (ticks first), -1 on timeout.
   task automatic wait_valid(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (o_valid) begin n = i; break; end
      end
   endtask

   // Cycles until o_done is seen (ticks first), -1 on timeout.
   task automatic wait_done(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (o_done) begin n = i; break; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
      checks++; if (o_lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b want 0", o_lockup); end
      checks++; if (o_word !== 8'h00) begin errors++; $display("FAIL reset_word: got %h want 00", o_word); end
      checks++; if (o_state !== 5'h01) begin errors++; $display("FAIL reset_state: got %h want 01", o_state); end
   endtask

   task automatic test_single_word();
      int n;
      int dones;
      cfg(5'h01, 5'h14);
      i_ready = 1'b1;
      start(8'd1);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", o_busy); end
      wait_valid(20, n);
      // start edge plus 8 shift edges = 9 cycles from i_start
      checks++; if (n !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8 after start edge", n); end
      checks++; if (o_word !== 8'h09) begin errors++; $display("FAIL single_word: got %h want 09", o_word); end
      checks++; if (o_state !== 5'h0C) begin errors++; $display("FAIL single_state: got %h want 0c", o_state); end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (o_done) dones++;
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", dones); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", o_busy); end
   endtask

   task automatic test_period();
      int hs;
      int seen_done;
      logic [7:0] first;
      do_reset();
      i_ready = 1'b1;
      hs = 0; seen_done = 0; first = 8'h00;
      start(8'd31);
      for (int i = 0; i < 400; i++) begin
         tick();
         if (o_valid) begin
            hs++;
            if (hs == 1) first = o_word;
         end
         if (o_done) begin seen_done = 1; break; end
      end
      checks++; if (seen_done !== 1) begin errors++; $display("FAIL period_timeout: done seen=%0d want 1", seen_done); end
      checks++; if (hs !== 31) begin errors++; $display("FAIL period_handshakes: got %0d want 31", hs); end
      checks++; if (first !== 8'h09) begin errors++; $display("FAIL period_first_word: got %h want 09", first); end
      checks++; if (o_state !== 5'h01) begin errors++; $display("FAIL period_state: got %h want 01", o_state); end
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      i_ready = 1'b0;
      start(8'd3);
      wait_valid(20, n);
      checks++; if (o_word !== 8'h09) begin errors++; $display("FAIL bp_word1: got %h want 09", o_word); end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b want 1", o_valid); end
         checks++; if (o_word !== 8'h09) begin errors++; $display("FAIL bp_word_hold: got %h want 09", o_word); end
         checks++; if (o_state !== 5'h0C) begin errors++; $display("FAIL bp_state_hold: got %h want 0c", o_state); end
      end
      i_ready = 1'b1;
      wait_valid(20, n);
      checks++; if (o_word !== 8'h67) begin errors++; $display("FAIL bp_word2: got %h want 67", o_word); end
      checks++; if (o_state !== 5'h18) begin errors++; $display("FAIL bp_state2: got %h want 18", o_state); end
      wait_valid(20, n);
      checks++; if (o_word !== 8'hC6) begin errors++; $display("FAIL bp_word3: got %h want c6", o_word); end
      checks++; if (o_state !== 5'h1D) begin errors++; $display("FAIL bp_state3: got %h want 1d", o_state); end
      wait_done(10, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", n); end
   endtask

   task automatic test_lockup();
      int n;
      do_reset();
      cfg(5'h00, 5'h14);
      checks++; if (o_state !== 5'h00) begin errors++; $display("FAIL lock_cfg_state: got %h want 00", o_state); end
      i_ready = 1'b1;
      start(8'd1);
      tick();
      checks++; if (o_lockup !== 1'b1) begin errors++; $display("FAIL lock_flag: got %b want 1", o_lockup); end
      checks++; if (o_state !== 5'h01) begin errors++; $display("FAIL lock_reload: got %h want 01", o_state); end
      wait_valid(20, n);
      checks++; if (n !== 8) begin errors++; $display("FAIL lock_latency: got %0d want 8 after reload", n); end
      checks++; if (o_word !== 8'h09) begin errors++; $display("FAIL lock_word: got %h want 09", o_word); end
      wait_done(10, n);
      tick();
      checks++; if (o_lockup !== 1'b1) begin errors++; $display("FAIL lock_sticky: got %b want 1", o_lockup); end
      cfg(5'h01, 5'h14);
      checks++; if (o_lockup !== 1'b0) begin errors++; $display("FAIL lock_clear: got %b want 0", o_lockup); end
   endtask

   task automatic test_stop_continuous();
      int n;
      int valids;
      logic [7:0] exp_words [3];
      exp_words[0] = 8'h09; exp_words[1] = 8'h67; exp_words[2] = 8'hC6;
      do_reset();
      i_ready = 1'b1;
      start(8'd0);
      for (int k = 0; k < 5; k++) begin
         wait_valid(20, n);
         checks++; if (n < 0) begin errors++; $display("FAIL cont_word_timeout: word %0d got %0d", k, n); end
         if (k < 3) begin
            checks++; if (o_word !== exp_words[k]) begin errors++; $display("FAIL cont_word: idx %0d got %h want %h", k, o_word, exp_words[k]); end
         end
      end
      tick();  // accept word 5
      tick(); tick(); tick();  // 3 steps into word 6
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stop_shift_done: got %b want 1", o_done); end
      // 43 steps from seed, period 31 -> 12 steps -> 0F
      checks++; if (o_state !== 5'h0F) begin errors++; $display("FAIL stop_shift_state: got %h want 0f", o_state); end
      valids = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_valid) valids++;
      end
      checks++; if (valids !== 0) begin errors++; $display("FAIL stop_shift_novalid: got %0d want 0", valids); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_shift_busy: got %b want 0", o_busy); end

      // stop together with a handshake
      start(8'd0);
      wait_valid(20, n);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stop_hs_done: got %b want 1", o_done); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stop_hs_valid: got %b want 0", o_valid); end

      // stop while stalled: word dropped
      tick();
      i_ready = 1'b0;
      start(8'd0);
      wait_valid(20, n);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stop_drop_done: got %b want 1", o_done); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stop_drop_valid: got %b want 0", o_valid); end
      tick();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_drop_busy: got %b want 0", o_busy); end
   endtask

   task automatic test_ignored();
      int n;
      do_reset();
      i_ready = 1'b1;
      start(8'd2);
      tick(); tick();
      i_cfg_we = 1'b1; i_cfg_seed = 5'h1F; i_cfg_taps = 5'h03; i_start = 1'b1; i_num_words = 8'd9;
      tick();
      i_cfg_we = 1'b0; i_start = 1'b0;
      wait_valid(20, n);
      checks++; if (o_word !== 8'h09) begin errors++; $display("FAIL busy_cmd_word1: got %h want 09", o_word); end
      wait_valid(20, n);
      checks++; if (o_word !== 8'h67) begin errors++; $display("FAIL busy_cmd_word2: got %h want 67", o_word); end
      wait_done(10, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL busy_cmd_done: got %0d want 1", n); end
      tick();
      checks++; if (o_state !== 5'h18) begin errors++; $display("FAIL busy_cmd_state: got %h want 18", o_state); end

      // cfg and start together in IDLE: config only
      i_cfg_we = 1'b1; i_cfg_seed = 5'h0C; i_cfg_taps = 5'h14; i_start = 1'b1; i_num_words = 8'd1;
      tick();
      i_cfg_we = 1'b0; i_start = 1'b0;
      tick();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cfg_start_busy: got %b want 0", o_busy); end
      checks++; if (o_state !== 5'h0C) begin errors++; $display("FAIL cfg_start_state: got %h want 0c", o_state); end
      start(8'd1);
      wait_valid(20, n);
      checks++; if (o_word !== 8'h67) begin errors++; $display("FAIL cfg_start_word: got %h want 67", o_word); end
      wait_done(10, n);
      tick();
   endtask

   task automatic test_rst_mid();
      int n;
      i_ready = 1'b0;
      start(8'd1);
      wait_valid(20, n);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid: got %b want 1", o_valid); end
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
      checks++; if (o_state !== 5'h01) begin errors++; $display("FAIL rst_mid_state: got %h want 01", o_state); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
   endtask

   initial begin
      i_rst = 1'b0; i_cfg_we = 1'b0; i_cfg_seed = 5'h00; i_cfg_taps = 5'h00;
      i_start = 1'b0; i_num_words = 8'd0; i_stop = 1'b0; i_ready = 1'b0;
      test_reset();
      test_single_word();
      test_period();
      test_backpressure();
      test_lockup();
      test_stop_continuous();
      test_ignored();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencer for a runtime-configurable Fibonacci LFSR. It holds the LFSR's seed and tap registers and steps the LFSR WORD_BITS times per word. Random bits are packed into words and handed downstream over a valid/ready handshake. It runs for a programmed word count, or continuously until stopped, and sits between the host/config logic and any consumer of random words (test pattern generators, LED effects, UART PRBS).

Parameters:
NUM_BITS, 5, LFSR width (>=3)
WORD_BITS, 8, bits per output word (>=2)
SEED, 5'd1, reset value of seed and state registers; must be nonzero
TAPS, 5'h14, reset value of tap register (x^5+x^3+1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_cfg_we  in  1  config write strobe; honoured only in IDLE
i_cfg_seed  in  NUM_BITS  new seed; also loaded into LFSR state
i_cfg_taps  in  NUM_BITS  new tap mask
i_start  in  1  start pulse; honoured only in IDLE
i_num_words  in  8  words to produce, sampled on i_start; 0 = continuous
i_stop  in  1  abort/stop request
i_ready  in  1  downstream accepts word
o_word  out  WORD_BITS  packed random word
o_valid  out  1  o_word valid
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at end of run
o_lockup  out  1  sticky: all-zero state was detected and recovered
o_state  out  NUM_BITS  current LFSR state (debug)

Behaviour:
- Reset: state=SEED, seed reg=SEED, taps reg=TAPS, FSM=IDLE, o_word=0, o_valid=0, o_busy=0, o_done=0, o_lockup=0, counters=0.
- LFSR step: fb = XOR-reduce(state & taps). out_bit = state[NUM_BITS-1] before the step. next = {state[NUM_BITS-2:0], fb}.
- Word packing: word <= {word[WORD_BITS-2:0], out_bit}. The first generated bit ends up in the MSB.
- FSM states: IDLE, SHIFT, PRESENT, DONE.
- IDLE:
  - If i_cfg_we: seed reg, state <= i_cfg_seed; taps <= i_cfg_taps; o_lockup <= 0. A simultaneous i_start is ignored.
  - Otherwise, if i_start: latch i_num_words, clear word counter, go to SHIFT.
  - A cfg seed of 0 is accepted and handled by lockup recovery.
- SHIFT:
  - Exactly WORD_BITS cycles, one LFSR step per cycle, driven by a bit counter 0..WORD_BITS-1.
  - On the first SHIFT cycle of each word, if state==0: state <= seed reg (or SEED if seed reg==0), o_lockup <= 1. That cycle performs no step, and the word starts one cycle later.
  - After the last bit: o_word <= packed word, o_valid <= 1, go to PRESENT.
- PRESENT:
  - o_valid and o_word are held stable until i_ready.
  - On o_valid&&i_ready: o_valid <= 0 and word count increments (8-bit wrap, irrelevant in continuous mode).
  - Then, if (num_words!=0 && count+1==num_words) go to DONE; else go to SHIFT.
  - The LFSR does not step in PRESENT; backpressure never loses or skips bits.
- DONE: o_done=1 for one cycle, then IDLE.
- i_stop, in SHIFT: the partial word is discarded, state keeps the steps already taken, go to DONE.
- i_stop, in PRESENT:
  - If i_ready is high the same cycle, the word is accepted first, then DONE.
  - Otherwise o_valid <= 0, the word is dropped, then DONE.
- i_stop in IDLE/DONE: no effect.
- i_cfg_we / i_start outside IDLE: ignored, no queuing.
- LFSR state persists across runs; a new run continues the sequence unless re-seeded.
- i_rst mid-run: returns to reset values next edge; o_valid drops immediately at that edge.
- Latency: i_start to first o_valid = WORD_BITS+1 cycles (no lockup). Minimum cadence with i_ready held high is one word per WORD_BITS+1 cycles.

Test Plan:
- Reset defaults, cfg seed=1 taps=5'h14, start num_words=1, i_ready=1:
  - o_valid rises 9 cycles after i_start with o_word=8'h09.
  - o_state=5'h0C.
  - o_done pulses once, o_busy falls.
- Period check: num_words=31, i_ready=1:
  - 248 steps; after o_done, o_state==5'h01 (seed).
  - First word 8'h09; exactly 31 handshakes.
- Backpressure: hold i_ready=0 for 20 cycles in PRESENT. o_word and o_state are stable throughout; after release the next word matches the no-stall reference sequence.
- Lockup: cfg seed=0, start num_words=1:
  - o_lockup=1 and state reloads to SEED (5'h01).
  - The word is delivered one cycle later than normal, value 8'h09.
  - A subsequent cfg write clears o_lockup.
- Stop/continuous: num_words=0 runs indefinitely.
  - i_stop mid-SHIFT: no further o_valid, o_done pulses.
  - i_stop with o_valid&&i_ready in the same cycle: the word counts as delivered, then o_done.
- Ignored commands:
  - i_cfg_we and i_start during busy have no effect.
  - i_cfg_we with i_start in IDLE: config applied, no run started.
  - i_rst mid-PRESENT: o_valid=0 and state=SEED the next cycle.
